fp_mul_pipe: RTL
================

// Module: fp_mul_pipe
// PURPOSE
//   Parametrised, pipelined IEEE-754 floating-point multiplier; successor to the single-cycle fp32 multiplier.
//   Format set by EXP_W/FRAC_W (default binary32). Round-to-nearest-even, full special-case handling, exception flags.
//   valid/ready on input and output so it can sit between FPU operand and result queues under backpressure.
// PARAMETERS
//   EXP_W    8   exponent field width (>=3); BIAS = 2**(EXP_W-1)-1
//   FRAC_W   23  stored fraction width (>=2); hidden bit implicit
//   W        -   localparam = 1+EXP_W+FRAC_W, operand/result width
// PORTS
//   clk        in   1  clock, rising edge
//   rst_n      in   1  asynchronous active-low reset
//   in_valid   in   1  operands a/b valid this cycle
//   in_ready   out  1  block accepts operands this cycle
//   a          in   W  operand A {sign,exp,frac}
//   b          in   W  operand B {sign,exp,frac}
//   out_valid  out  1  op/flags valid
//   out_ready  in   1  downstream accepts result
//   op         out  W  product
//   flags      out  4  {invalid,overflow,underflow,inexact}, sticky per result only (not accumulated)
// BEHAVIOUR
//   Reset (async, rst_n=0): all stage valid bits 0; out_valid=0, op=0, flags=0; in-flight ops discarded, no output after release.
//   Pipeline: 3 stages, latency 3 cycles from accepted input to out_valid when never stalled; throughput 1/clk.
//     S1 decode/classify + exponent sum; S2 (FRAC_W+1)x(FRAC_W+1) mantissa product; S3 normalise, round, pack, flags.
//   Handshake: transfer on in_valid&in_ready and on out_valid&out_ready.
//     stall = out_valid & ~out_ready; stall freezes all stages; in_ready = ~stall (combinational, no other dependency).
//     Bubbles are not squeezed. op/flags held stable while out_valid&~out_ready.
//     Simultaneous input accept and output drain in same cycle is legal, no loss.
//   Classification (per operand): exp=0 -> zero (subnormal inputs treated as zero, DAZ); exp=all-1s & frac=0 -> inf; exp=all-1s & frac!=0 -> NaN.
//   Sign = sa ^ sb for all non-NaN results.
//   Special results (priority order):
//     any NaN in, or inf*zero -> canonical qNaN {0, all-1s, 1,0..0}; invalid=1 only for inf*zero or sNaN input (frac MSB=0)
//     inf*(nonzero) -> signed inf, no flags; zero*(finite) -> signed zero, no flags
//   Normal path:
//     e = ea + eb - BIAS, computed in EXP_W+2 bit signed; m = {1,fa}*{1,fb}, 2*FRAC_W+2 bits.
//     If m MSB set: shift right 1, e+1. Guard = next bit below kept fraction, sticky = OR of rest.
//     RNE: increment if G & (S | LSB). Mantissa carry-out on round -> fraction 0, e+1.
//     inexact = G|S.
//     e >= 2**EXP_W-1 after rounding -> signed inf, overflow=1, inexact=1.
//     e <= 0 -> signed zero (FTZ), underflow=1, inexact=1.
//   No combinational path a/b -> op.
// TESTING (binary32 defaults)
//   2.0*3.0: 0x40000000 * 0x40400000 -> op=0x40C00000, flags=0, out_valid 3 cycles after accept
//   Rounding: 0x3F800001 * 0x3F800001 -> 0x3F800002, inexact=1; 1.5*1.5 (0x3FC00000^2) -> 0x40100000, flags=0
//   Specials: 0x7F800000 * 0x00000000 -> 0x7FC00000, invalid=1;
//     0xFF800000 * 0x40000000 -> 0xFF800000;
//     0x7F800001 * 0x3F800000 -> 0x7FC00000, invalid=1
//   Range: 0x7F7FFFFF * 0x40000000 -> 0x7F800000, overflow=1, inexact=1;
//     0x00800000 * 0x00800000 -> 0x00000000, underflow=1, inexact=1
//   Backpressure: stream 8 back-to-back ops with out_ready toggled 1/0/0/1 pattern
//     -> in_ready=~stall, results in order, none dropped or duplicated, op stable while stalled
//   Reset mid-flight: accept 2 ops, assert rst_n=0 asynchronously between edges
//     -> out_valid=0 immediately; no stale result after release; next op has 3-cycle latency

Source files
------------

// File: rtl/fp_mul_pipe.sv
// Pipelined IEEE-754 multiplier: S1 classify/exponent sum, S2 mantissa product, S3 normalise/round/pack.
// Round-to-nearest-even, DAZ inputs, FTZ outputs; valid/ready with whole-pipe stall on output backpressure.
module fp_mul_pipe #(
   parameter  int EXP_W  = 8,
   parameter  int FRAC_W = 23,
   localparam int W      = 1 + EXP_W + FRAC_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] op,
   output logic [3:0]   flags
);

   localparam int EW   = EXP_W + 2;
   localparam int MW   = 2 * FRAC_W + 2;
   localparam int BIAS = 2 ** (EXP_W - 1) - 1;
   localparam logic [EW-1:0] BIAS_E = EW'(BIAS);
   localparam logic [EW-1:0] E_MAX  = EW'((2 ** EXP_W) - 1);
   localparam logic [W-1:0]  QNAN   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};

   logic stall;

   // ---------------- stage 1: classify, special results, exponent sum
   logic [EXP_W-1:0]  ea, eb;
   logic [FRAC_W-1:0] fa, fb;
   logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan, inf_zero;

   logic              sgn1_d, spec1_d, inv1_d;
   logic [W-1:0]      sres1_d;
   logic [EW-1:0]     e1_d;

   logic              v1_q, sgn1_q, spec1_q, inv1_q;
   logic [W-1:0]      sres1_q;
   logic [EW-1:0]     e1_q;
   logic [FRAC_W:0]   ma1_q, mb1_q;

   always_comb begin
      ea       = a[W-2 -: EXP_W];
      eb       = b[W-2 -: EXP_W];
      fa       = a[FRAC_W-1:0];
      fb       = b[FRAC_W-1:0];
      a_zero   = (ea == '0);
      b_zero   = (eb == '0);
      a_inf    = (ea == '1) && (fa == '0);
      b_inf    = (eb == '1) && (fb == '0);
      a_nan    = (ea == '1) && (fa != '0);
      b_nan    = (eb == '1) && (fb != '0);
      a_snan   = a_nan && !fa[FRAC_W-1];
      b_snan   = b_nan && !fb[FRAC_W-1];
      inf_zero = (a_inf && b_zero) || (a_zero && b_inf);

      sgn1_d  = a[W-1] ^ b[W-1];
      spec1_d = 1'b0;
      inv1_d  = 1'b0;
      sres1_d = '0;
      if (a_nan || b_nan || inf_zero) begin
         spec1_d = 1'b1;
         sres1_d = QNAN;
         inv1_d  = inf_zero || a_snan || b_snan;
      end else if (a_inf || b_inf) begin
         spec1_d = 1'b1;
         sres1_d = {sgn1_d, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      end else if (a_zero || b_zero) begin
         spec1_d = 1'b1;
         sres1_d = {sgn1_d, {(W-1){1'b0}}};
      end
      // Unsigned wrap yields the two's-complement biased sum; sign bit read later.
      e1_d = {2'b00, ea} + {2'b00, eb} - BIAS_E;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q    <= 1'b0;
         sgn1_q  <= 1'b0;
         spec1_q <= 1'b0;
         inv1_q  <= 1'b0;
         sres1_q <= '0;
         e1_q    <= '0;
         ma1_q   <= '0;
         mb1_q   <= '0;
      end else if (!stall) begin
         v1_q    <= in_valid;
         sgn1_q  <= sgn1_d;
         spec1_q <= spec1_d;
         inv1_q  <= inv1_d;
         sres1_q <= sres1_d;
         e1_q    <= e1_d;
         ma1_q   <= {1'b1, fa};
         mb1_q   <= {1'b1, fb};
      end
   end

   // ---------------- stage 2: mantissa product
   logic              v2_q, sgn2_q, spec2_q, inv2_q;
   logic [W-1:0]      sres2_q;
   logic [EW-1:0]     e2_q;
   logic [MW-1:0]     m2_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v2_q    <= 1'b0;
         sgn2_q  <= 1'b0;
         spec2_q <= 1'b0;
         inv2_q  <= 1'b0;
         sres2_q <= '0;
         e2_q    <= '0;
         m2_q    <= '0;
      end else if (!stall) begin
         v2_q    <= v1_q;
         sgn2_q  <= sgn1_q;
         spec2_q <= spec1_q;
         inv2_q  <= inv1_q;
         sres2_q <= sres1_q;
         e2_q    <= e1_q;
         m2_q    <= MW'(ma1_q) * MW'(mb1_q);
      end
   end

   // ---------------- stage 3: normalise, round, pack, flags
   logic [MW-2:0]     mn;
   logic [FRAC_W-1:0] frac, frac_r;
   logic              g, s, rnd, cy, ovf, unf;
   logic [EW-1:0]     e_n;
   logic [W-1:0]      res_d;
   logic [3:0]        fl_d;

   logic              v3_q;
   logic [W-1:0]      op_q;
   logic [3:0]        flags_q;

   always_comb begin
      // Product lies in [1,4); align so the hidden bit sits just above mn.
      mn          = m2_q[MW-1] ? m2_q[MW-2:0] : {m2_q[MW-3:0], 1'b0};
      frac        = mn[MW-2 -: FRAC_W];
      g           = mn[FRAC_W];
      s           = |mn[FRAC_W-1:0];
      rnd         = g && (s || frac[0]);
      {cy, frac_r} = {1'b0, frac} + (FRAC_W+1)'(rnd);
      e_n         = e2_q + EW'(m2_q[MW-1]) + EW'(cy);
      ovf         = !e_n[EW-1] && (e_n >= E_MAX);
      unf         = e_n[EW-1] || (e_n == '0);

      res_d = {sgn2_q, e_n[EXP_W-1:0], frac_r};
      fl_d  = {3'b000, g || s};
      if (spec2_q) begin
         res_d = sres2_q;
         fl_d  = {inv2_q, 3'b000};
      end else if (ovf) begin
         res_d = {sgn2_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
         fl_d  = 4'b0101;
      end else if (unf) begin
         res_d = {sgn2_q, {(W-1){1'b0}}};
         fl_d  = 4'b0011;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v3_q    <= 1'b0;
         op_q    <= '0;
         flags_q <= '0;
      end else if (!stall) begin
         v3_q <= v2_q;
         if (v2_q) begin
            op_q    <= res_d;
            flags_q <= fl_d;
         end
      end
   end

   assign stall     = v3_q && !out_ready;
   assign in_ready  = !stall;
   assign out_valid = v3_q;
   assign op        = op_q;
   assign flags     = flags_q;

endmodule
